// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit scheduler.
package gmii_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        FLUSH,
        IFG
    } tx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_DEFAULT   = 8'hD5;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gmii_tx_scheduler_arb.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_arbiter2
    import gmii_tx_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Winner selection is purely combinational; the caller registers the result.
    always_comb begin
        gnt_valid = enable && (req != 2'b00);
        gnt_idx   = 1'b0;
        unique case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/gmii_tx_scheduler.sv
// Two-requester GMII transmit scheduler: frame-level round-robin, preamble/SFD
// insertion, payload streaming, underrun abort with flush, inter-frame gap.
module gmii_tx_scheduler
    import gmii_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_LEN      = 12,
    parameter logic [7:0]  SFD_BYTE     = SFD_DEFAULT
) (
    input  logic       gmii_tx_clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       grant,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN);
    localparam logic [7:0] IFG_LAST = 8'(IFG_LEN - 1);

    tx_state_e  state_q;
    logic       grant_q;
    logic       last_grant_q;
    logic       aborted_q;
    logic [3:0] pre_cnt_q;
    logic [7:0] ifg_cnt_q;
    logic [7:0] txd_q;
    logic       en_q;
    logic       er_q;
    logic       done_q;
    logic       underrun_q;

    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       in_payload;
    logic       arb_enable;
    logic       arb_valid;
    logic       arb_idx;

    assign sel_valid  = grant_q ? req1_valid : req0_valid;
    assign sel_data   = grant_q ? req1_data  : req0_data;
    assign sel_last   = grant_q ? req1_last  : req0_last;

    assign in_payload = (state_q == DATA) || (state_q == FLUSH);
    assign req0_ready = in_payload && (grant_q == 1'b0);
    assign req1_ready = in_payload && (grant_q == 1'b1);

    assign arb_enable = (state_q == IDLE);

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = en_q;
    assign gmii_tx_er = er_q;
    assign busy       = (state_q != IDLE);
    assign grant      = grant_q;
    assign frame_done = done_q;
    assign underrun   = underrun_q;

    rr_arbiter2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .enable     (arb_enable),
        .gnt_valid  (arb_valid),
        .gnt_idx    (arb_idx)
    );

    // Frame sequencer: owns every registered GMII output and status pulse.
    always_ff @(posedge gmii_tx_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            aborted_q    <= 1'b0;
            pre_cnt_q    <= '0;
            ifg_cnt_q    <= '0;
            txd_q        <= '0;
            en_q         <= 1'b0;
            er_q         <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    er_q <= 1'b0;
                    if (arb_valid) begin
                        grant_q      <= arb_idx;
                        last_grant_q <= arb_idx;
                        txd_q        <= PREAMBLE_BYTE;
                        en_q         <= 1'b1;
                        pre_cnt_q    <= 4'd1;
                        state_q      <= PREAMBLE;
                    end else begin
                        txd_q <= '0;
                        en_q  <= 1'b0;
                    end
                end
                PREAMBLE: begin
                    en_q <= 1'b1;
                    er_q <= 1'b0;
                    if (pre_cnt_q == PRE_LAST) begin
                        txd_q   <= SFD_BYTE;
                        state_q <= DATA;
                    end else begin
                        txd_q     <= PREAMBLE_BYTE;
                        pre_cnt_q <= sat_inc4(pre_cnt_q);
                    end
                end
                DATA: begin
                    en_q <= 1'b1;
                    if (sel_valid) begin
                        txd_q <= sel_data;
                        er_q  <= 1'b0;
                        if (sel_last) begin
                            aborted_q <= 1'b0;
                            ifg_cnt_q <= '0;
                            state_q   <= IFG;
                        end
                    end else begin
                        txd_q      <= '0;
                        er_q       <= 1'b1;
                        underrun_q <= 1'b1;
                        state_q    <= FLUSH;
                    end
                end
                FLUSH: begin
                    txd_q <= '0;
                    en_q  <= 1'b0;
                    er_q  <= 1'b0;
                    if (sel_valid && sel_last) begin
                        aborted_q <= 1'b1;
                        ifg_cnt_q <= '0;
                        state_q   <= IFG;
                    end
                end
                IFG: begin
                    txd_q <= '0;
                    en_q  <= 1'b0;
                    er_q  <= 1'b0;
                    if ((ifg_cnt_q == 8'd0) && !aborted_q) begin
                        done_q <= 1'b1;
                    end
                    if (ifg_cnt_q == IFG_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        ifg_cnt_q <= sat_inc8(ifg_cnt_q);
                    end
                end
                default: begin
                    txd_q   <= '0;
                    en_q    <= 1'b0;
                    er_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Self-checking bench for gmii_tx_scheduler: requester byte queues feed the DUT,
// an expected-byte queue is filled alongside and drained while gmii_tx_en is high.
module tb_gmii_tx_scheduler;

    localparam int unsigned PRE  = 7;
    localparam int unsigned IFGN = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, busy, grant, frame_done, underrun;

    always #4 clk = ~clk;

    gmii_tx_scheduler #(
        .PREAMBLE_LEN (PRE),
        .IFG_LEN      (IFGN),
        .SFD_BYTE     (8'hD5)
    ) dut (
        .gmii_tx_clk (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_last   (req0_last),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_last   (req1_last),
        .req1_ready  (req1_ready),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .grant       (grant),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    logic [8:0] src0[$];   // {last, data}
    logic [8:0] src1[$];
    logic [8:0] exp_q[$];  // {er, txd} for every cycle with tx_en high
    int hole1 = -1;        // req1 drops valid for one cycle once cons1 reaches this
    int cons1 = 0;
    int n_checks = 0;
    int n_fail = 0;

    task automatic drive();
        req0_valid = (src0.size() != 0);
        req0_data  = (src0.size() != 0) ? src0[0][7:0] : 8'h00;
        req0_last  = (src0.size() != 0) ? src0[0][8] : 1'b0;
        req1_valid = (src1.size() != 0) && (cons1 != hole1);
        req1_data  = (src1.size() != 0) ? src1[0][7:0] : 8'h00;
        req1_last  = (src1.size() != 0) ? src1[0][8] : 1'b0;
    endtask

    task automatic tick();
        logic f0, f1, held1;
        f0    = req0_valid && req0_ready;
        f1    = req1_valid && req1_ready;
        held1 = (src1.size() != 0) && (cons1 == hole1) && req1_ready;
        @(posedge clk);
        #1;
        if (f0) src0.delete(0);
        if (f1) begin
            src1.delete(0);
            cons1++;
        end
        if (held1) hole1 = -1;
        drive();
    endtask

    task automatic add_frame(input int req, input int n, input logic [7:0] base,
                             input logic [7:0] step, input bit with_exp);
        if (with_exp) begin
            for (int i = 0; i < int'(PRE); i++) exp_q.push_back({1'b0, 8'h55});
            exp_q.push_back({1'b0, 8'hD5});
        end
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = base + 8'(i) * step;
            if (req == 0) src0.push_back({(i == n - 1), d});
            else          src1.push_back({(i == n - 1), d});
            if (with_exp) exp_q.push_back({1'b0, d});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        add_frame(0, 2, 8'h11, 8'h01, 1'b0);
        drive();
        tick();
        tick();
        n_checks++;
        if ({gmii_txd, gmii_tx_en, gmii_tx_er} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_tx: txd=%02h en=%b er=%b, required 00/0/0", gmii_txd, gmii_tx_en, gmii_tx_er);
        end
        n_checks++;
        if ({busy, grant, frame_done, underrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b grant=%b done=%b ur=%b, required all 0", busy, grant, frame_done, underrun);
        end
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: ready0=%b ready1=%b, required 0/0", req0_ready, req1_ready);
        end
        src0.delete();
        drive();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({busy, gmii_tx_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b en=%b, required 0/0", busy, gmii_tx_en);
        end
    endtask

    task automatic test_single_frame();
        int en_cnt = 0, fd_cnt = 0, er_cnt = 0, last_en = -1, fd_at = -2;
        logic [8:0] e;
        add_frame(0, 3, 8'h0A, 8'h11, 1'b1);
        drive();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gmii_tx_en) begin
                en_cnt++;
                last_en = c;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL single_extra: txd=%02h er=%b, required no byte", gmii_txd, gmii_tx_er);
                end else begin
                    e = exp_q.pop_front();
                    if ({gmii_tx_er, gmii_txd} !== e) begin
                        n_fail++;
                        $display("FAIL single_byte: er=%b txd=%02h, required er=%b txd=%02h", gmii_tx_er, gmii_txd, e[8], e[7:0]);
                    end
                end
            end
            if (gmii_tx_er) er_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_at = c;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_missing: %0d bytes not seen, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (en_cnt != 11) begin
            n_fail++;
            $display("FAIL single_en_len: %0d cycles, required 11", en_cnt);
        end
        n_checks++;
        if (fd_cnt != 1 || fd_at != last_en + 1) begin
            n_fail++;
            $display("FAIL single_done: %0d pulses at %0d, required 1 at %0d", fd_cnt, fd_at, last_en + 1);
        end
        n_checks++;
        if (er_cnt != 0) begin
            n_fail++;
            $display("FAIL single_er: %0d cycles, required 0", er_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_g[$];
        logic [8:0] e;
        bit prev_en = 1'b0, seen = 1'b0;
        int low_run = 0, gaps = 0, bad_ready = 0;
        reset = 1'b1;
        drive();
        tick();
        reset = 1'b0;
        add_frame(0, 2, 8'hA0, 8'h01, 1'b1);
        add_frame(1, 2, 8'hB0, 8'h01, 1'b1);
        add_frame(0, 2, 8'hC0, 8'h01, 1'b1);
        add_frame(1, 2, 8'hD0, 8'h01, 1'b1);
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        drive();
        for (int c = 0; c < 130; c++) begin
            tick();
            if ((req0_ready && grant != 1'b0) || (req1_ready && grant != 1'b1)) bad_ready++;
            if (gmii_tx_en && !prev_en) begin
                n_checks++;
                if (exp_g.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_frame: grant=%b, required no frame", grant);
                end else begin
                    e[0] = exp_g.pop_front();
                    if (grant !== e[0]) begin
                        n_fail++;
                        $display("FAIL b2b_grant: grant=%b, required %b", grant, e[0]);
                    end
                end
                if (seen) begin
                    gaps++;
                    n_checks++;
                    if (low_run != int'(IFGN)) begin
                        n_fail++;
                        $display("FAIL b2b_gap: %0d low cycles, required %0d", low_run, IFGN);
                    end
                end
            end
            if (!gmii_tx_en && prev_en) begin
                seen = 1'b1;
                low_run = 1;
            end else if (!gmii_tx_en) begin
                low_run++;
            end
            if (gmii_tx_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: txd=%02h, required no byte", gmii_txd);
                end else begin
                    e = exp_q.pop_front();
                    if ({gmii_tx_er, gmii_txd} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_byte: er=%b txd=%02h, required er=%b txd=%02h", gmii_tx_er, gmii_txd, e[8], e[7:0]);
                    end
                end
            end
            prev_en = gmii_tx_en;
        end
        n_checks++;
        if (exp_q.size() != 0 || exp_g.size() != 0 || gaps != 3) begin
            n_fail++;
            $display("FAIL b2b_complete: %0d bytes, %0d frames left, %0d gaps, required 0/0/3", exp_q.size(), exp_g.size(), gaps);
            exp_q.delete();
        end
        n_checks++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL b2b_ready_owner: %0d cycles with non-granted ready, required 0", bad_ready);
        end
    endtask

    task automatic test_underrun();
        int en_cnt = 0, er_cnt = 0, ur_cnt = 0, ur_er = 0, fd_cnt = 0, ifg_cnt = 0;
        logic [8:0] e;
        cons1 = 0;
        hole1 = 2;
        add_frame(1, 5, 8'h31, 8'h01, 1'b0);
        for (int i = 0; i < int'(PRE); i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b0, 8'h32});
        exp_q.push_back({1'b1, 8'h00});
        drive();
        for (int c = 0; c < 50; c++) begin
            tick();
            if (gmii_tx_en) begin
                en_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ur_extra: txd=%02h er=%b, required no byte", gmii_txd, gmii_tx_er);
                end else begin
                    e = exp_q.pop_front();
                    if ({gmii_tx_er, gmii_txd} !== e) begin
                        n_fail++;
                        $display("FAIL ur_byte: er=%b txd=%02h, required er=%b txd=%02h", gmii_tx_er, gmii_txd, e[8], e[7:0]);
                    end
                end
            end
            if (gmii_tx_er) er_cnt++;
            if (underrun) ur_cnt++;
            if (underrun && gmii_tx_er) ur_er++;
            if (frame_done) fd_cnt++;
            if (busy && !req0_ready && !req1_ready && !gmii_tx_en) ifg_cnt++;
        end
        n_checks++;
        if (exp_q.size() != 0 || en_cnt != 11) begin
            n_fail++;
            $display("FAIL ur_frame: %0d bytes missing, %0d en cycles, required 0/11", exp_q.size(), en_cnt);
            exp_q.delete();
        end
        n_checks++;
        if (er_cnt != 1 || ur_cnt != 1 || ur_er != 1) begin
            n_fail++;
            $display("FAIL ur_pulse: er=%0d ur=%0d together=%0d, required 1/1/1", er_cnt, ur_cnt, ur_er);
        end
        n_checks++;
        if (fd_cnt != 0) begin
            n_fail++;
            $display("FAIL ur_no_done: %0d done pulses, required 0", fd_cnt);
        end
        n_checks++;
        if (src1.size() != 0) begin
            n_fail++;
            $display("FAIL ur_flush: %0d bytes left, required 0", src1.size());
            src1.delete();
        end
        n_checks++;
        if (ifg_cnt != int'(IFGN)) begin
            n_fail++;
            $display("FAIL ur_ifg: %0d gap cycles, required %0d", ifg_cnt, IFGN);
        end
        hole1 = -1;
        drive();
    endtask

    task automatic test_reset_mid_payload();
        bit found = 1'b0, prev_en = 1'b0;
        int frames = 0;
        logic first_grant = 1'b1;
        logic [8:0] e;
        add_frame(0, 8, 8'h41, 8'h01, 1'b1);
        drive();
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (gmii_tx_en) begin
                n_checks++;
                e = exp_q.pop_front();
                if ({gmii_tx_er, gmii_txd} !== e) begin
                    n_fail++;
                    $display("FAIL rst_mid_byte: er=%b txd=%02h, required er=%b txd=%02h", gmii_tx_er, gmii_txd, e[8], e[7:0]);
                end
                if (gmii_txd == 8'h45) found = 1'b1;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_reach: byte 45 not seen, required within 40 cycles");
        end
        reset = 1'b1;
        src0.delete();
        exp_q.delete();
        drive();
        tick();
        n_checks++;
        if ({gmii_tx_en, gmii_tx_er, busy, req0_ready, req1_ready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rst_mid_state: en=%b er=%b busy=%b r0=%b r1=%b, required all 0", gmii_tx_en, gmii_tx_er, busy, req0_ready, req1_ready);
        end
        reset = 1'b0;
        add_frame(0, 2, 8'h51, 8'h01, 1'b1);
        add_frame(1, 2, 8'h61, 8'h01, 1'b1);
        drive();
        for (int c = 0; c < 70; c++) begin
            tick();
            if (gmii_tx_en && !prev_en) begin
                if (frames == 0) first_grant = grant;
                frames++;
            end
            if (gmii_tx_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rst_after_extra: txd=%02h, required no byte", gmii_txd);
                end else begin
                    e = exp_q.pop_front();
                    if ({gmii_tx_er, gmii_txd} !== e) begin
                        n_fail++;
                        $display("FAIL rst_after_byte: er=%b txd=%02h, required er=%b txd=%02h", gmii_tx_er, gmii_txd, e[8], e[7:0]);
                    end
                end
            end
            prev_en = gmii_tx_en;
        end
        n_checks++;
        if (first_grant !== 1'b0 || frames != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_after_order: first grant=%b frames=%0d left=%0d, required 0/2/0", first_grant, frames, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ifg_request();
        bit prev_en = 1'b0, seen = 1'b0, pushed = 1'b0;
        int low_run = 0, idle_run = 0, rises = 0;
        logic [8:0] e;
        add_frame(0, 2, 8'h71, 8'h01, 1'b1);
        drive();
        for (int c = 0; c < 60; c++) begin
            tick();
            if (gmii_tx_en && !prev_en) begin
                rises++;
                if (seen) begin
                    n_checks++;
                    if (low_run != int'(IFGN)) begin
                        n_fail++;
                        $display("FAIL ifg_req_gap: %0d low cycles, required %0d", low_run, IFGN);
                    end
                    n_checks++;
                    if (idle_run != 1 || grant !== 1'b1) begin
                        n_fail++;
                        $display("FAIL ifg_req_start: idle=%0d grant=%b, required 1/1", idle_run, grant);
                    end
                end
            end
            if (!gmii_tx_en && prev_en) begin
                seen = 1'b1;
                low_run = 1;
            end else if (!gmii_tx_en) begin
                low_run++;
            end
            idle_run = busy ? 0 : idle_run + 1;
            if (seen && !pushed && low_run == 3) begin
                pushed = 1'b1;
                add_frame(1, 1, 8'h81, 8'h01, 1'b1);
                drive();
            end
            if (gmii_tx_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ifg_req_extra: txd=%02h, required no byte", gmii_txd);
                end else begin
                    e = exp_q.pop_front();
                    if ({gmii_tx_er, gmii_txd} !== e) begin
                        n_fail++;
                        $display("FAIL ifg_req_byte: er=%b txd=%02h, required er=%b txd=%02h", gmii_tx_er, gmii_txd, e[8], e[7:0]);
                    end
                end
            end
            prev_en = gmii_tx_en;
        end
        n_checks++;
        if (rises != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ifg_req_frames: %0d frames, %0d bytes left, required 2/0", rises, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_single_byte();
        int en_cnt = 0, fd_cnt = 0, last_en = -1, fd_at = -2;
        logic [8:0] e;
        add_frame(0, 1, 8'hF9, 8'h01, 1'b1);
        drive();
        for (int c = 0; c < 30; c++) begin
            tick();
            if (gmii_tx_en) begin
                en_cnt++;
                last_en = c;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL one_byte_extra: txd=%02h, required no byte", gmii_txd);
                end else begin
                    e = exp_q.pop_front();
                    if ({gmii_tx_er, gmii_txd} !== e) begin
                        n_fail++;
                        $display("FAIL one_byte_byte: er=%b txd=%02h, required er=%b txd=%02h", gmii_tx_er, gmii_txd, e[8], e[7:0]);
                    end
                end
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = c;
            end
        end
        n_checks++;
        if (en_cnt != int'(PRE) + 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL one_byte_len: %0d en cycles, %0d left, required %0d/0", en_cnt, exp_q.size(), PRE + 2);
            exp_q.delete();
        end
        n_checks++;
        if (fd_cnt != 1 || fd_at != last_en + 1) begin
            n_fail++;
            $display("FAIL one_byte_done: %0d pulses at %0d, required 1 at %0d", fd_cnt, fd_at, last_en + 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_reset_mid_payload();
        test_ifg_request();
        test_single_byte();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_tx_scheduler.md
Name: gmii_tx_scheduler

Overview:
- Two-requester GMII transmit scheduler in the gmii_tx_clk domain, driving the GMII side of gmii2rgmii.
- Arbitrates whole frames between requester 0 and requester 1 using round-robin.
- Prepends the preamble and SFD, streams payload bytes, then enforces the inter-frame gap.
- On payload underrun it signals tx_er and flushes the rest of the frame. Requesters supply complete frames including FCS.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD (range 1..15)
IFG_LEN, 12, idle cycles with gmii_tx_en low after each frame (range 1..255)
SFD_BYTE, 8'hD5, start-of-frame delimiter value

Ports:
gmii_tx_clk  in  1  125 MHz transmit clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a byte available / requests a frame
req0_data  in  8  requester 0 payload byte
req0_last  in  1  qualifies the final byte of the frame
req0_ready  out  1  byte accepted on the edge where valid && ready
req1_valid, req1_data, req1_last, req1_ready  same as requester 0
gmii_txd  out  8  to gmii2rgmii
gmii_tx_en  out  1  to gmii2rgmii
gmii_tx_er  out  1  to gmii2rgmii
busy  out  1  state != IDLE
grant  out  1  index of the requester owning the current frame
frame_done  out  1  one-cycle pulse: frame completed normally
underrun  out  1  one-cycle pulse: frame aborted

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=1, so requester 0 wins the first tie.
- Reset is synchronous and active-high. Asserting it mid-frame drops gmii_tx_en on the next edge; no tx_er is generated.
- gmii_txd, gmii_tx_en and gmii_tx_er are registered. reqN_ready is combinational: ready = (state==DATA || state==FLUSH) && grant==N.
- IDLE:
  - If any reqN_valid is high, pick a winner: only one valid → that one; both valid → the requester != last_grant.
  - On that edge: grant<=winner, last_grant<=winner, txd<=0x55, en<=1, cnt<=1, state->PREAMBLE. No byte is consumed.
- PREAMBLE:
  - Each edge outputs 0x55 and increments cnt.
  - When cnt==PREAMBLE_LEN, output SFD_BYTE instead and go to DATA.
  - Result: exactly PREAMBLE_LEN x 0x55, then one SFD byte.
- DATA:
  - valid && ready: txd<=data, en<=1, er<=0.
  - If last is also set, go to IFG, then en<=0 on the following edge and pulse frame_done on that edge.
  - Payload is back-to-back with the SFD when the requester keeps valid high.
  - Underrun (granted valid low in DATA): txd<=0, en<=1, er<=1 for one cycle; pulse underrun; go to FLUSH.
- FLUSH:
  - en=0, er=0. ready stays high and bytes are discarded until a last byte is accepted, then go to IFG.
- IFG:
  - en=0 for exactly IFG_LEN cycles, counted from the first cycle en is low, then go to IDLE.
  - Requests that arrive during IFG wait; arbitration is evaluated in IDLE only.
- The non-granted requester's ready is always 0. Its valid may stay high indefinitely without effect.
- A frame whose first DATA cycle has valid low is an underrun: SFD followed by tx_er.
- Counters: cnt is 4 bits for preamble and 8 bits for IFG; counts saturate and never wrap.
- Frame length is unbounded; the block does no length check.

Decomposition:
- Package gmii_tx_pkg holds:
  - the state enum IDLE/PREAMBLE/DATA/FLUSH/IFG;
  - the constants PREAMBLE_BYTE=8'h55 and SFD default 8'hD5.
- One sub-module: rr_arbiter2, a 2-way round-robin arbiter. Inputs: req[1:0], last_grant, enable. Outputs: gnt_valid, gnt_idx.
- Everything else is a single FSM in the top module.

Test Plan:
- Single frame: req0 sends 0x0A,0x1B,0x2C (last) with valid held high → gmii_txd = 55 x7, D5, 0A, 1B, 2C with tx_en high for 11 cycles; then tx_en low for 12 cycles; frame_done pulses once; tx_er never high.
- Tie: both requesters valid in the same IDLE cycle → req0 frame is sent first, then IFG, then req1; with both continuously requesting, grants alternate 0,1,0,1 over 4 frames.
- Underrun: req1 drops valid for one cycle after its 2nd payload byte → one cycle of tx_en=1, tx_er=1, txd=00; underrun pulse; remaining bytes are consumed with tx_en=0; IFG=12 follows.
- Reset mid-payload: assert reset during byte 5 → next edge tx_en=0, busy=0, both readies 0; the next frame starts with a full preamble and req0 has priority.
- Request during IFG: req1 raises valid 3 cycles into the IFG → tx_en stays low for the full 12 cycles; preamble starts on the cycle after the block returns to IDLE.
- Single-byte frame: byte 0xF9 with last set on the first byte → output is 55 x7, D5, F9; frame_done pulses one cycle after F9.
